burst_pulse_sequencer: RTL and testbench

Programmable burst-pulse scheduler that generates the modulated clock stream `clkMod` for the downstream modulator. On a `start` handshake it emits `cfgBursts` bursts of `cfgPulses` one-cycle-high / one-cycle-low pulses, with `cfgGap` idle-low cycles between bursts. Defaults (7 pulses, gap 2) reproduce the fixed 16-cycle frame used elsewhere in the design. Unlike the fixed generator, `clkMod` is registered and glitch-free.

---
 rtl/burst_seq_pkg.sv | 23 ++
 rtl/burst_pulse_sequencer_if.sv | 33 +++
 rtl/seq_down_counter.sv | 31 +++
 rtl/burst_pulse_sequencer.sv | 171 +++++++++++++++++
 tb/tb_burst_pulse_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/burst_seq_pkg.sv
// Shared types and constants for the burst pulse sequencer.
//   seq_state_t  : sequencer FSM state encoding
//   DEF_PULSES   : default pulses per burst (reproduces the fixed 16-cycle frame)
//   DEF_GAP      : default idle-low cycles between bursts
//   isActive()   : true for states that produce the pulse stream (busy)
package burst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        GAP,
        DONE
    } seq_state_t;

    localparam int unsigned DEF_PULSES = 7;
    localparam int unsigned DEF_GAP    = 2;

    function automatic logic isActive(input seq_state_t s);
        return (s == HI) || (s == LO) || (s == GAP);
    endfunction

endpackage

// File: rtl/burst_pulse_sequencer_if.sv
// Control/status bundle between a requester and the burst pulse sequencer.
//   start, abort          : run request and immediate stop (abort wins)
//   cfgPulses/Gap/Bursts  : run configuration, sampled on an accepted start
//   clkMod                : modulated pulse stream
//   busy, done, burstCnt  : run status
// master drives requests and config; slave is the sequencer.
interface burst_pulse_sequencer_if #(
    parameter int unsigned P_W = 4,
    parameter int unsigned G_W = 4,
    parameter int unsigned B_W = 8
);

    logic           start;
    logic           abort;
    logic [P_W-1:0] cfgPulses;
    logic [G_W-1:0] cfgGap;
    logic [B_W-1:0] cfgBursts;
    logic           clkMod;
    logic           busy;
    logic           done;
    logic [B_W-1:0] burstCnt;

    modport master (
        output start, abort, cfgPulses, cfgGap, cfgBursts,
        input  clkMod, busy, done, burstCnt
    );

    modport slave (
        input  start, abort, cfgPulses, cfgGap, cfgBursts,
        output clkMod, busy, done, burstCnt
    );

endinterface

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag.
//   sysClk, sysRst : clock and synchronous active-high reset
//   load, loadVal  : load a new value (takes priority over dec)
//   dec            : decrement by one (wraps below zero; callers never do that)
//   zero           : current count is zero
module seq_down_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             sysClk,
    input  logic             sysRst,
    input  logic             load,
    input  logic [Width-1:0] loadVal,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] countQ;

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            countQ <= '0;
        end else if (load) begin
            countQ <= loadVal;
        end else if (dec) begin
            countQ <= countQ - Width'(1);
        end
    end

    assign zero = (countQ == '0);

endmodule

// File: rtl/burst_pulse_sequencer.sv
// Programmable burst-pulse scheduler producing the registered modulated clock clkMod.
// A run is cfgBursts bursts of cfgPulses high/low pulse pairs with cfgGap low cycles
// between bursts; cfgBursts = 0 runs until abort.
//   sysClk, sysRst : clock and synchronous active-high reset
//   bus (slave)    : start/abort, config inputs, clkMod/busy/done/burstCnt outputs
module burst_pulse_sequencer
    import burst_seq_pkg::*;
#(
    parameter int unsigned P_W = 4,
    parameter int unsigned G_W = 4,
    parameter int unsigned B_W = 8
) (
    input logic                    sysClk,
    input logic                    sysRst,
    burst_pulse_sequencer_if.slave bus
);

    // The default frame must be expressible with the chosen counter widths.
    if (DEF_PULSES > (2 ** P_W) - 1 || DEF_GAP > (2 ** G_W) - 1) begin : gDefaultCheck
        $error("counter widths too narrow for default frame");
    end

    seq_state_t     stateQ, stateD;
    logic [P_W-1:0] cfgPulsesQ;
    logic [G_W-1:0] cfgGapQ;
    logic [B_W-1:0] cfgBurstsQ;
    logic [B_W-1:0] burstCntQ, burstCntD;
    logic           clkModQ, busyQ, doneQ;
    logic           cfgLatch;

    logic           pulseLoad, pulseDec, pulseZero;
    logic [P_W-1:0] pulseLoadVal;
    logic           gapLoad, gapDec, gapZero;
    logic [G_W-1:0] gapLoadVal;

    logic [B_W-1:0] burstCntInc;
    logic           runDone;

    // Counters hold "cycles remaining after this one", so they are loaded with N-1 and
    // the zero flag marks the final LO of a burst / final GAP cycle.
    seq_down_counter #(
        .Width(P_W)
    ) uPulseCnt (
        .sysClk (sysClk),
        .sysRst (sysRst),
        .load   (pulseLoad),
        .loadVal(pulseLoadVal),
        .dec    (pulseDec),
        .zero   (pulseZero)
    );

    seq_down_counter #(
        .Width(G_W)
    ) uGapCnt (
        .sysClk (sysClk),
        .sysRst (sysRst),
        .load   (gapLoad),
        .loadVal(gapLoadVal),
        .dec    (gapDec),
        .zero   (gapZero)
    );

    assign gapLoadVal = cfgGapQ - G_W'(1);

    // Continuous mode saturates instead of wrapping.
    assign burstCntInc = (cfgBurstsQ == '0 && burstCntQ == '1) ? burstCntQ
                                                                : burstCntQ + B_W'(1);
    assign runDone     = (cfgBurstsQ != '0) && ((burstCntQ + B_W'(1)) == cfgBurstsQ);

    always_comb begin
        stateD       = stateQ;
        burstCntD    = burstCntQ;
        cfgLatch     = 1'b0;
        pulseLoad    = 1'b0;
        pulseLoadVal = cfgPulsesQ - P_W'(1);
        pulseDec     = 1'b0;
        gapLoad      = 1'b0;
        gapDec       = 1'b0;

        unique case (stateQ)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    cfgLatch  = 1'b1;
                    burstCntD = '0;
                    if (bus.cfgPulses == '0) begin
                        stateD = DONE;
                    end else begin
                        // Config is latched on this same edge, so load from the inputs.
                        pulseLoad    = 1'b1;
                        pulseLoadVal = bus.cfgPulses - P_W'(1);
                        stateD       = HI;
                    end
                end
            end
            HI: begin
                stateD = bus.abort ? IDLE : LO;
            end
            LO: begin
                if (bus.abort) begin
                    stateD = IDLE;
                end else if (!pulseZero) begin
                    pulseDec = 1'b1;
                    stateD   = HI;
                end else begin
                    burstCntD = burstCntInc;
                    if (runDone) begin
                        stateD = DONE;
                    end else if (cfgGapQ != '0) begin
                        gapLoad = 1'b1;
                        stateD  = GAP;
                    end else begin
                        pulseLoad = 1'b1;
                        stateD    = HI;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    stateD = IDLE;
                end else if (gapZero) begin
                    pulseLoad = 1'b1;
                    stateD    = HI;
                end else begin
                    gapDec = 1'b1;
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change only on
    // the clock edge and never glitch.
    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            stateQ    <= IDLE;
            burstCntQ <= '0;
            clkModQ   <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            burstCntQ <= burstCntD;
            clkModQ   <= (stateD == HI);
            busyQ     <= isActive(stateD);
            doneQ     <= (stateD == DONE);
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            cfgPulsesQ <= '0;
            cfgGapQ    <= '0;
            cfgBurstsQ <= '0;
        end else if (cfgLatch) begin
            cfgPulsesQ <= bus.cfgPulses;
            cfgGapQ    <= bus.cfgGap;
            cfgBurstsQ <= bus.cfgBursts;
        end
    end

    assign bus.clkMod   = clkModQ;
    assign bus.busy     = busyQ;
    assign bus.done     = doneQ;
    assign bus.burstCnt = burstCntQ;

endmodule

// File: tb/tb_burst_pulse_sequencer.sv
module tb_burst_pulse_sequencer;
    import burst_seq_pkg::*;

    logic sysClk = 1'b0;
    logic sysRst;

    burst_pulse_sequencer_if #(.P_W(4), .G_W(4), .B_W(8)) bus ();

    burst_pulse_sequencer #(
        .P_W(4),
        .G_W(4),
        .B_W(8)
    ) dut (
        .sysClk(sysClk),
        .sysRst(sysRst),
        .bus   (bus)
    );

    always #5 sysClk = ~sysClk;

    // One run: config applied with start in cycle 0; per-cycle expected outputs as
    // '0'/'1' strings indexed by cycle; expCnt is burstCnt in the final cycle.
    typedef struct {
        string      name;
        logic [3:0] p;
        logic [3:0] g;
        logic [7:0] b;
        int         abortCyc;
        bit         mutate;
        string      expClk;
        string      expBusy;
        string      expDone;
        logic [7:0] expCnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic string rep(input string s, input int n);
        string r = "";
        for (int i = 0; i < n; i++) r = {r, s};
        return r;
    endfunction

    function automatic vec_t mkVec(input string name, input int p, input int g, input int b,
                                   input int abortCyc, input bit mutate, input string eClk,
                                   input string eBusy, input string eDone, input int eCnt);
        vec_t v;
        v.name     = name;
        v.p        = 4'(p);
        v.g        = 4'(g);
        v.b        = 8'(b);
        v.abortCyc = abortCyc;
        v.mutate   = mutate;
        v.expClk   = eClk;
        v.expBusy  = eBusy;
        v.expDone  = eDone;
        v.expCnt   = 8'(eCnt);
        return v;
    endfunction

    task automatic check(input string what, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", what, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sysClk);
        #1;
    endtask

    task automatic checkIdle(input string tag, input logic [7:0] cnt);
        check({tag, " clkMod"}, {7'd0, bus.clkMod}, 8'd0);
        check({tag, " busy"}, {7'd0, bus.busy}, 8'd0);
        check({tag, " done"}, {7'd0, bus.done}, 8'd0);
        check({tag, " burstCnt"}, bus.burstCnt, cnt);
    endtask

    task automatic runVec(input vec_t v);
        int len = v.expClk.len();
        for (int c = 0; c < len; c++) begin
            bus.start = (c == 0) || (v.mutate && (c == 3 || c == 20 || c == 31));
            bus.abort = (c == v.abortCyc);
            if (c == 0 || !v.mutate) begin
                bus.cfgPulses = v.p;
                bus.cfgGap    = v.g;
                bus.cfgBursts = v.b;
            end else begin
                bus.cfgPulses = 4'($urandom);
                bus.cfgGap    = 4'($urandom);
                bus.cfgBursts = 8'($urandom);
            end
            check($sformatf("%s c%0d clkMod", v.name, c), {7'd0, bus.clkMod},
                  {7'd0, v.expClk.getc(c) == 8'h31});
            check($sformatf("%s c%0d busy", v.name, c), {7'd0, bus.busy},
                  {7'd0, v.expBusy.getc(c) == 8'h31});
            check($sformatf("%s c%0d done", v.name, c), {7'd0, bus.done},
                  {7'd0, v.expDone.getc(c) == 8'h31});
            if (c == len - 1) begin
                check($sformatf("%s burstCnt", v.name), bus.burstCnt, v.expCnt);
            end
            step();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    vec_t vecs[7];
    string defClk, defBusy, defDone;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        defClk  = {"0", rep("10", 7), "00", rep("10", 7), "00"};
        defBusy = {"0", rep("1", 30), "00"};
        defDone = {rep("0", 31), "1", "0"};

        vecs[0] = mkVec("default", DEF_PULSES, DEF_GAP, 2, -1, 1'b0,
                        defClk, defBusy, defDone, 2);
        vecs[1] = mkVec("gap0", 3, 0, 2, -1, 1'b0,
                        {"0", rep("10", 6), "000"}, {"0", rep("1", 12), "000"},
                        {rep("0", 13), "1", "00"}, 2);
        vecs[2] = mkVec("pulses0", 0, 2, 5, -1, 1'b0,
                        "0000", "0000", "0100", 0);
        vecs[3] = mkVec("contAbort", 2, 1, 0, 12, 1'b0,
                        {"0", rep("10", 2), "0", rep("10", 2), "0", "10", "000"},
                        {"0", rep("1", 12), "000"}, rep("0", 16), 2);
        vecs[4] = mkVec("oneBurst", 1, 3, 1, -1, 1'b0,
                        "01000", "01100", "00010", 1);
        vecs[5] = mkVec("p1g1b3", 1, 1, 3, -1, 1'b0,
                        {"0", rep("100", 3), "0"}, {"0", rep("1", 8), "00"},
                        {rep("0", 9), "1", "0"}, 3);
        vecs[6] = mkVec("interfere", DEF_PULSES, DEF_GAP, 2, -1, 1'b1,
                        defClk, defBusy, defDone, 2);

        // Reset state
        sysRst        = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cfgPulses = '0;
        bus.cfgGap    = '0;
        bus.cfgBursts = '0;
        step();
        step();
        checkIdle("reset", 8'd0);
        sysRst = 1'b0;

        foreach (vecs[i]) runVec(vecs[i]);

        // start together with abort in IDLE: nothing happens, burstCnt holds
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        bus.cfgPulses = 4'd3;
        bus.cfgGap    = 4'd1;
        bus.cfgBursts = 8'd1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checkIdle($sformatf("startAbort c%0d", c), 8'd2);
            step();
        end

        // Reset in the middle of the first gap
        bus.start     = 1'b1;
        bus.cfgPulses = 4'd7;
        bus.cfgGap    = 4'd2;
        bus.cfgBursts = 8'd2;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        check("midGap c15 clkMod", {7'd0, bus.clkMod}, 8'd0);
        check("midGap c15 busy", {7'd0, bus.busy}, 8'd1);
        check("midGap c15 burstCnt", bus.burstCnt, 8'd1);
        sysRst = 1'b1;
        step();
        sysRst = 1'b0;
        checkIdle("rstGap c16", 8'd0);
        step();
        checkIdle("rstGap c17", 8'd0);

        runVec(mkVec("afterRst", 2, 0, 1, -1, 1'b0,
                     "0101000", "0111100", "0000010", 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
